div_arbiter: RTL
================

DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter WIDTH, default 64, operand/result width.
REQ-002 Parameter NR_REQ, default 2, number of requesters (2..4).
REQ-003 clk_i  in  1  clock; single clock domain.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 req_vld_i  in  NR_REQ  per-requester request valid.
REQ-006 req_rdy_o  out  NR_REQ  per-requester accept; one-hot or zero.
REQ-007 req_op_a_i / req_op_b_i  in  NR_REQ x WIDTH  dividend / divisor per requester.
REQ-008 req_opcode_i  in  NR_REQ x 2  0 udiv, 1 div, 2 urem, 3 rem.
REQ-009 req_id_i  in  NR_REQ x TRANS_ID_BITS  transaction id per requester.
REQ-010 flush_i  in  1  abort any in-flight operation.
REQ-011 resp_vld_o  out  NR_REQ  result valid, routed to owning requester only.
REQ-012 resp_rdy_i  in  NR_REQ  per-requester result ready.
REQ-013 resp_id_o / resp_res_o  out  TRANS_ID_BITS / WIDTH  shared result id and value.
REQ-014 div_op_a_o, div_op_b_o, div_opcode_o, div_id_o  out  divider operand bus, driven from internal registers.
REQ-015 div_in_vld_o  out  1; div_in_rdy_i  in  1; divider input handshake.
REQ-016 div_out_vld_i  in  1; div_out_rdy_o  out  1; div_id_i, div_res_i  in  divider result bus.
REQ-017 div_flush_o  out  1  flush to divider.
REQ-018 err_o  out  1  sticky id-mismatch error.

Function
REQ-019 FSM states IDLE, ISSUE, BUSY; one divider operation in flight at most.
REQ-020 IDLE: if div_in_rdy_i=1 and any req_vld_i, grant = first valid requester at or after rr_ptr (wrapping at NR_REQ); req_rdy_o[grant]=1 that cycle; operands, opcode, id, owner latched; -> ISSUE.
REQ-021 IDLE with div_in_rdy_i=0: no grant; all req_rdy_o=0; stay IDLE.
REQ-022 ISSUE: div_in_vld_o=1 for exactly one cycle, from latched registers; -> BUSY unconditionally.
REQ-023 div_in_vld_o SHALL never be high outside ISSUE; req_rdy_o SHALL never be high outside IDLE.
REQ-024 BUSY: resp_vld_o[owner]=div_out_vld_i, others 0; resp_id_o=div_id_i; resp_res_o=div_res_i (combinational pass-through); div_out_rdy_o=resp_rdy_i[owner].
REQ-025 BUSY: when div_out_vld_i & resp_rdy_i[owner]: rr_ptr <= owner+1 mod NR_REQ; -> IDLE; new grant possible the next cycle.
REQ-026 Response stall (resp_rdy_i[owner]=0) holds BUSY indefinitely; result data taken from divider unchanged.
REQ-027 Minimum accept-to-accept spacing = divider latency + 2 cycles.
REQ-028 On divider result handshake, if div_id_i != latched id, err_o <= 1 (sticky until reset); response still forwarded.
REQ-029 flush_i: div_flush_o=flush_i same cycle; req_rdy_o, div_in_vld_o, resp_vld_o forced 0; state -> IDLE next cycle; rr_ptr unchanged; err_o unchanged.
REQ-030 flush_i coincident with an IDLE grant cancels it: no req_rdy_o, no latch, no ISSUE.
REQ-031 req_vld_i from non-granted requesters ignored; requester keeps request until req_rdy_o.

Reset
REQ-032 rst_ni=0 asynchronously: state IDLE, rr_ptr 0, owner 0, latched operands/opcode/id 0, err_o 0.
REQ-033 During and directly after reset all outputs 0 except div_op_*/div_id_o=0 and req_rdy_o=0; first grant possible in first cycle after release.

Verification
REQ-034 req0: a=100, b=7, opcode 0, id 3 -> one req_rdy_o[0] pulse, one div_in_vld_o pulse next cycle, resp_vld_o[0] with res 14, id 3; resp_vld_o[1]=0 throughout.
REQ-035 Both requesters valid from reset (req1: a=-20, b=6, opcode 3) -> req0 served first, then req1 with res -2; third simultaneous round serves req0 only after req1 completes (rr order 0,1,0).
REQ-036 div_in_rdy_i held 0 for 5 cycles with req0 valid -> req_rdy_o=0 for those cycles; grant in first cycle rdy=1.
REQ-037 flush_i asserted 3 cycles after ISSUE -> div_flush_o=1 same cycle, no resp_vld_o, IDLE next cycle, pending req1 granted afterward with rr_ptr unchanged.
REQ-038 resp_rdy_i[0]=0 for 4 cycles with result valid -> div_out_rdy_o=0, result held stable, delivered on release.
REQ-039 Divider returns id 5 for latched id 3 -> err_o=1 next cycle, stays 1 through later transactions until rst_ni=0.

Source files
------------

// File: rtl/div_arbiter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module      : div_arbiter
//  Description : Round-robin front end that lets NR_REQ requesters share one
//                divider with at most one operation in flight. Routes the
//                result back to the owning requester and flags id mismatches.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_arbiter #(
  parameter int WIDTH         = 64,
  parameter int NR_REQ        = 2,
  parameter int TRANS_ID_BITS = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  // requester side
  input  logic [NR_REQ-1:0]                      req_vld_i,
  output logic [NR_REQ-1:0]                      req_rdy_o,
  input  logic [NR_REQ-1:0][WIDTH-1:0]           req_op_a_i,
  input  logic [NR_REQ-1:0][WIDTH-1:0]           req_op_b_i,
  input  logic [NR_REQ-1:0][1:0]                 req_opcode_i,
  input  logic [NR_REQ-1:0][TRANS_ID_BITS-1:0]   req_id_i,
  input  logic                                   flush_i,
  output logic [NR_REQ-1:0]                      resp_vld_o,
  input  logic [NR_REQ-1:0]                      resp_rdy_i,
  output logic [TRANS_ID_BITS-1:0]               resp_id_o,
  output logic [WIDTH-1:0]                       resp_res_o,
  // divider side
  output logic [WIDTH-1:0]                       div_op_a_o,
  output logic [WIDTH-1:0]                       div_op_b_o,
  output logic [1:0]                             div_opcode_o,
  output logic [TRANS_ID_BITS-1:0]               div_id_o,
  output logic                                   div_in_vld_o,
  input  logic                                   div_in_rdy_i,
  input  logic                                   div_out_vld_i,
  output logic                                   div_out_rdy_o,
  input  logic [TRANS_ID_BITS-1:0]               div_id_i,
  input  logic [WIDTH-1:0]                       div_res_i,
  output logic                                   div_flush_o,
  output logic                                   err_o
);

  localparam int c_PTR_W  = $clog2(NR_REQ);
  localparam int c_SCAN_W = c_PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } state_e;

  state_e                     r_state;
  state_e                     w_state_next;
  logic [c_PTR_W-1:0]         r_rr_ptr;
  logic [c_PTR_W-1:0]         r_owner;
  logic [WIDTH-1:0]           r_op_a;
  logic [WIDTH-1:0]           r_op_b;
  logic [1:0]                 r_opcode;
  logic [TRANS_ID_BITS-1:0]   r_id;
  logic                       r_err;

  logic                       w_grant_any;
  logic [c_PTR_W-1:0]         w_grant_idx;
  logic [c_SCAN_W-1:0]        w_scan;
  logic                       w_accept;
  logic                       w_resp_hs;

  // Find the first valid requester at or after the round-robin pointer.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_scan      = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      w_scan = {1'b0, r_rr_ptr} + c_SCAN_W'(i);
      if (w_scan >= c_SCAN_W'(NR_REQ)) begin
        w_scan = w_scan - c_SCAN_W'(NR_REQ);
      end
      if (!w_grant_any && req_vld_i[w_scan[c_PTR_W-1:0]]) begin
        w_grant_any = 1'b1;
        w_grant_idx = w_scan[c_PTR_W-1:0];
      end
    end
  end

  // A grant is suppressed while reset is held so no request is consumed then.
  assign w_accept  = rst_ni && (r_state == IDLE) && div_in_rdy_i && w_grant_any && !flush_i;
  assign w_resp_hs = (r_state == BUSY) && div_out_vld_i && resp_rdy_i[r_owner] && !flush_i;

  // Next-state and handshake outputs; flush overrides everything.
  always_comb begin
    w_state_next  = r_state;
    req_rdy_o     = '0;
    div_in_vld_o  = 1'b0;
    resp_vld_o    = '0;
    div_out_rdy_o = 1'b0;
    resp_id_o     = '0;
    resp_res_o    = '0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          req_rdy_o[w_grant_idx] = 1'b1;
          w_state_next           = ISSUE;
        end
      end
      ISSUE: begin
        div_in_vld_o = 1'b1;
        w_state_next = BUSY;
      end
      BUSY: begin
        resp_vld_o[r_owner] = div_out_vld_i;
        resp_id_o           = div_id_i;
        resp_res_o          = div_res_i;
        div_out_rdy_o       = resp_rdy_i[r_owner];
        if (w_resp_hs) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
    if (flush_i) begin
      req_rdy_o     = '0;
      div_in_vld_o  = 1'b0;
      resp_vld_o    = '0;
      div_out_rdy_o = 1'b0;
      w_state_next  = IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Capture the granted request so the divider bus is stable during ISSUE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_owner  <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_opcode <= '0;
      r_id     <= '0;
    end else if (w_accept) begin
      r_owner  <= w_grant_idx;
      r_op_a   <= req_op_a_i[w_grant_idx];
      r_op_b   <= req_op_b_i[w_grant_idx];
      r_opcode <= req_opcode_i[w_grant_idx];
      r_id     <= req_id_i[w_grant_idx];
    end
  end

  // Advance the round-robin pointer past the owner only on a completed result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr <= '0;
    end else if (w_resp_hs) begin
      r_rr_ptr <= (r_owner == c_PTR_W'(NR_REQ - 1)) ? '0 : r_owner + 1'b1;
    end
  end

  // Sticky flag for a result whose id does not match the issued one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if (w_resp_hs && (div_id_i != r_id)) begin
      r_err <= 1'b1;
    end
  end

  assign div_op_a_o   = r_op_a;
  assign div_op_b_o   = r_op_b;
  assign div_opcode_o = r_opcode;
  assign div_id_o     = r_id;
  assign div_flush_o  = flush_i;
  assign err_o        = r_err;

endmodule
`default_nettype wire
